emb_seq_block: RTL

//  Sequence-level embedding stage, directly upstream of the model core.

---
 rtl/emb_seq_block_pkg.sv | 35 +++
 rtl/emb_seq_block_emb.sv | 56 +++++
 rtl/emb_seq_block.sv | 131 +++++++++++++
 3 files changed

// File: rtl/emb_seq_block_pkg.sv
// ============================================================================
// Module  : emb_seq_block_pkg
// Purpose : Shared sizes, FSM state encoding and embedding-ROM contents for
//           the sequence-level embedding stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package emb_seq_block_pkg;

    localparam int CHAR_NUM = 10;   // characters per sequence
    localparam int EMB_DIM  = 24;   // elements per embedding vector
    localparam int N_LEN    = 16;   // bits per element
    localparam int CHAR_LEN = 8;    // bits per character code
    localparam int ADDR_W   = 16;   // embedding ROM address width
    localparam int IDX_W    = 4;    // character index counter width

    typedef enum logic [1:0] {
        EMB_SEQ_IDLE  = 2'd0,
        EMB_SEQ_LOAD  = 2'd1,
        EMB_SEQ_FETCH = 2'd2,
        EMB_SEQ_DONE  = 2'd3
    } emb_seq_state_e;

    // Embedding table contents: a fixed mixing of the address so every entry
    // is distinct and non-trivial without needing an external init file.
    function automatic logic [15:0] emb_rom_word(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = {16'b0, a} * 32'd40503;
        return t[15:0] ^ {3'b000, a[15:3]} ^ 16'h5A3C;
    endfunction

endpackage

`default_nettype wire

// File: rtl/emb_seq_block_emb.sv
// ============================================================================
// Module  : emb_seq_block_emb
// Purpose : Single-character embedding lookup (run/valid protocol).
//           While run_i=0 the start address EMB_DIM*d_i is loaded and the
//           element counter cleared. While run_i=1 one element per cycle is
//           read from the ROM into q_o; valid_o rises after EMB_DIM+1 run
//           cycles and is held until run_i drops.
// Ports   : clk, rst_n (async, active-low), run_i, d_i[CHAR_LEN],
//           valid_o, q_o[EMB_DIM*N_LEN] (elem k at q_o[k*N_LEN +: N_LEN])
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module emb_seq_block_emb
    import emb_seq_block_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run_i,
    input  logic [CHAR_LEN-1:0]        d_i,
    output logic                       valid_o,
    output logic [EMB_DIM*N_LEN-1:0]   q_o
);

    localparam int CNT_W = $clog2(EMB_DIM + 1);

    logic [ADDR_W-1:0]        addr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     valid_q;
    logic [EMB_DIM*N_LEN-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            q_q     <= '0;
        end else if (!run_i) begin
            addr_q  <= ADDR_W'(d_i) * ADDR_W'(EMB_DIM);
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (count_q < CNT_W'(EMB_DIM)) begin
            q_q[int'(count_q)*N_LEN +: N_LEN] <= emb_rom_word(addr_q + ADDR_W'(count_q));
            count_q <= count_q + CNT_W'(1);
        end else begin
            // One extra cycle after the last element before flagging valid.
            valid_q <= 1'b1;
        end
    end

    assign valid_o = valid_q;
    assign q_o     = q_q;

endmodule

`default_nettype wire

// File: rtl/emb_seq_block.sv
// ============================================================================
// Module  : emb_seq_block
// Purpose : Sequence-level embedding stage. Latches SEQ_LEN characters on the
//           rising of run_i, embeds them one at a time through a single
//           emb_seq_block_emb instance and collects the vectors into a
//           sequence buffer presented on q_o with a level valid_o.
// Ports   : clk, rst_n (async, active-low)
//           run_i    level; hold high for the whole operation, drop to restart
//           d_i      char i at d_i[i*CHAR_LEN +: CHAR_LEN]
//           valid_o  q_o complete; held while run_i stays high
//           q_o      elem k of char i at q_o[(i*EMB_DIM+k)*N_LEN +: N_LEN]
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module emb_seq_block
    import emb_seq_block_pkg::*;
#(
    parameter int SEQ_LEN = CHAR_NUM
)(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               run_i,
    input  logic [SEQ_LEN*CHAR_LEN-1:0]        d_i,
    output logic                               valid_o,
    output logic [SEQ_LEN*EMB_DIM*N_LEN-1:0]   q_o
);

    localparam int VEC_W = EMB_DIM * N_LEN;

    emb_seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [SEQ_LEN*CHAR_LEN-1:0] d_q;
    logic [VEC_W-1:0]            seq_buf_q [SEQ_LEN];

    logic                        w_emb_run;
    logic [CHAR_LEN-1:0]         w_emb_d;
    logic                        w_emb_valid;
    logic [VEC_W-1:0]            w_emb_q;
    logic                        w_latch;
    logic                        w_capture;
    logic [CHAR_LEN-1:0]         w_chars [SEQ_LEN];

    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_chars
        assign w_chars[i] = d_q[i*CHAR_LEN +: CHAR_LEN];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_emb_run = 1'b0;
        w_emb_d   = '0;
        w_latch   = 1'b0;
        w_capture = 1'b0;
        if (!run_i) begin
            // Restart from any state; the buffer is left untouched.
            state_d = EMB_SEQ_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                EMB_SEQ_IDLE: begin
                    idx_d   = '0;
                    w_latch = 1'b1;
                    state_d = EMB_SEQ_LOAD;
                end
                EMB_SEQ_LOAD: begin
                    // emb block samples its start address on this edge.
                    w_emb_d = w_chars[idx_q];
                    state_d = EMB_SEQ_FETCH;
                end
                EMB_SEQ_FETCH: begin
                    w_emb_run = 1'b1;
                    w_emb_d   = w_chars[idx_q];
                    if (w_emb_valid) begin
                        w_capture = 1'b1;
                        if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
                            state_d = EMB_SEQ_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = EMB_SEQ_LOAD;
                        end
                    end
                end
                EMB_SEQ_DONE: begin
                    state_d = EMB_SEQ_DONE;
                end
                default: begin
                    state_d = EMB_SEQ_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMB_SEQ_IDLE;
            idx_q   <= '0;
            d_q     <= '0;
            for (int i = 0; i < SEQ_LEN; i++) begin
                seq_buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (w_latch) begin
                d_q <= d_i;
            end
            if (w_capture) begin
                seq_buf_q[idx_q] <= w_emb_q;
            end
        end
    end

    emb_seq_block_emb emb_seq_inst (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_i   (w_emb_run),
        .d_i     (w_emb_d),
        .valid_o (w_emb_valid),
        .q_o     (w_emb_q)
    );

    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_flat
        assign q_o[i*VEC_W +: VEC_W] = seq_buf_q[i];
    end

    assign valid_o = (state_q == EMB_SEQ_DONE);

endmodule

`default_nettype wire
